// File: rtl/demux3_pkg.sv
// Shared definitions for the three-way buffered demultiplexer: channel ids,
// per-slot state encoding and the select decode.
package demux3_pkg;

    localparam int NUM_CH = 3;

    typedef enum logic [1:0] {
        CH0 = 2'd0,
        CH1 = 2'd1,
        CH2 = 2'd2
    } ch_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // Select 11 has no channel of its own and folds onto channel 2.
    function automatic ch_t sel_to_ch(input logic [1:0] sel);
        case (sel)
            2'b00:   return CH0;
            2'b01:   return CH1;
            default: return CH2;
        endcase
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer for a single demux channel, with a delivered-word
// counter that advances on every drain.
module demux_slot
    import demux3_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       cnt,
    output logic             can_load
);

    slot_state_t state;
    logic        drain;

    assign out_valid = (state == FULL);
    assign drain     = out_valid && out_ready;
    // A full slot can take a new word in the same cycle it hands its word on.
    assign can_load  = (state == EMPTY) || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            cnt      <= '0;
        end else begin
            if (drain) begin
                cnt <= cnt + 8'd1;
            end
            if (load) begin
                state    <= FULL;
                out_data <= load_data;
            end else if (drain) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: rtl/demux3_buf.sv
// Three-way demultiplexer: routes each accepted word to one of three
// independent one-entry channel buffers chosen by in_sel.
module demux3_buf
    import demux3_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
    output logic [7:0]       cnt2
);

    ch_t              ch;
    logic [NUM_CH-1:0] out_ready;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] can_load;
    logic [NUM_CH-1:0] load;
    logic [WIDTH-1:0]  out_data [NUM_CH];
    logic [7:0]        cnt      [NUM_CH];

    assign ch        = sel_to_ch(in_sel);
    assign out_ready = {out2_ready, out1_ready, out0_ready};
    // Readiness only looks at the addressed slot, so a stalled channel never
    // holds up traffic bound for another one.
    assign in_ready  = rst_n && can_load[ch];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        assign load[k] = in_valid && in_ready && (ch == ch_t'(k));

        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k]),
            .cnt       (cnt[k]),
            .can_load  (can_load[k])
        );
    end

    assign out0_data  = out_data[0];
    assign out1_data  = out_data[1];
    assign out2_data  = out_data[2];
    assign out0_valid = out_valid[0];
    assign out1_valid = out_valid[1];
    assign out2_valid = out_valid[2];
    assign cnt0       = cnt[0];
    assign cnt1       = cnt[1];
    assign cnt2       = cnt[2];

endmodule

// File: tb/tb_demux3_buf.sv
// Directed bench for demux3_buf: reset, routing, backpressure, channel
// independence, simultaneous load/drain and counter wrap.
module tb_demux3_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0_data, out1_data, out2_data;
    logic       out0_valid, out1_valid, out2_valid;
    logic       out0_ready, out1_ready, out2_ready;
    logic [7:0] cnt0, cnt1, cnt2;

    int checks = 0;
    int errors = 0;

    demux3_buf #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'b00; in_data = 8'h00;
        out0_ready = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if ({out2_valid, out1_valid, out0_valid} !== 3'b000) begin errors++; $display("[TB] FAIL por_valid: got %b expected 000", {out2_valid, out1_valid, out0_valid}); end
        checks++; if ({out2_data, out1_data, out0_data} !== 24'h0) begin errors++; $display("[TB] FAIL por_data: got %h expected 000000", {out2_data, out1_data, out0_data}); end
        checks++; if ({cnt2, cnt1, cnt0} !== 24'h0) begin errors++; $display("[TB] FAIL por_cnt: got %h expected 000000", {cnt2, cnt1, cnt0}); end

        // Fill channel 1 then reset while it is still holding its word.
        in_sel = 2'b01; in_data = 8'h99; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_sel = 2'b00;
        checks++; if (out1_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_full: got %b expected 1", out1_valid); end
        rst_n = 1'b0; out1_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL in_ready_in_reset: got %b expected 0", in_ready); end
        tick();
        checks++; if ({out2_valid, out1_valid, out0_valid} !== 3'b000) begin errors++; $display("[TB] FAIL mid_reset_valid: got %b expected 000", {out2_valid, out1_valid, out0_valid}); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL in_ready_in_reset2: got %b expected 0", in_ready); end
        tick();
        rst_n = 1'b1; out1_ready = 1'b0;
        tick();
        checks++; if ({cnt2, cnt1, cnt0} !== 24'h0) begin errors++; $display("[TB] FAIL mid_reset_cnt: got %h expected 000000", {cnt2, cnt1, cnt0}); end
        checks++; if (out1_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset_data: got %h expected 00", out1_data); end
    endtask

    task automatic test_routing();
        logic [7:0] vals [4];
        logic [7:0] got;
        logic       vld;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
        in_valid = 1'b0; in_sel = 2'b00;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_without_valid: got %b expected 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            in_sel = 2'(i); in_data = vals[i]; in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL route_ready_%0d: got %b expected 1", i, in_ready); end
            tick();
            case (i)
                0:       begin got = out0_data; vld = out0_valid; end
                1:       begin got = out1_data; vld = out1_valid; end
                default: begin got = out2_data; vld = out2_valid; end
            endcase
            checks++; if ({vld, got} !== {1'b1, vals[i]}) begin errors++; $display("[TB] FAIL route_%0d: got valid %b data %h expected valid 1 data %h", i, vld, got, vals[i]); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if ({cnt2, cnt1, cnt0} !== {8'd2, 8'd1, 8'd1}) begin errors++; $display("[TB] FAIL route_cnt: got %h expected 020101", {cnt2, cnt1, cnt0}); end
        checks++; if ({out2_valid, out1_valid, out0_valid} !== 3'b000) begin errors++; $display("[TB] FAIL route_drained: got %b expected 000", {out2_valid, out1_valid, out0_valid}); end
    endtask

    task automatic test_backpressure();
        out1_ready = 1'b0;
        in_sel = 2'b01; in_data = 8'h5A; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_ready: got %b expected 1", in_ready); end
        tick();
        in_data = 8'h6B;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_second_ready: got %b expected 0", in_ready); end
        tick();
        checks++; if ({out1_valid, out1_data} !== {1'b1, 8'h5A}) begin errors++; $display("[TB] FAIL bp_hold: got valid %b data %h expected valid 1 data 5a", out1_valid, out1_data); end
        tick();
        checks++; if (out1_data !== 8'h5A) begin errors++; $display("[TB] FAIL bp_hold2: got %h expected 5a", out1_data); end
        out1_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if ({out1_valid, out1_data} !== {1'b1, 8'h6B}) begin errors++; $display("[TB] FAIL bp_second_word: got valid %b data %h expected valid 1 data 6b", out1_valid, out1_data); end
        checks++; if (cnt1 !== 8'd2) begin errors++; $display("[TB] FAIL bp_cnt_mid: got %0d expected 2", cnt1); end
        tick();
        checks++; if ({out1_valid, cnt1} !== {1'b0, 8'd3}) begin errors++; $display("[TB] FAIL bp_done: got valid %b cnt %0d expected valid 0 cnt 3", out1_valid, cnt1); end
    endtask

    task automatic test_independence();
        out2_ready = 1'b0; out0_ready = 1'b1;
        in_sel = 2'b10; in_data = 8'hC2; in_valid = 1'b1;
        tick();
        in_sel = 2'b00; in_data = 8'h77;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL indep_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if ({out0_valid, out0_data} !== {1'b1, 8'h77}) begin errors++; $display("[TB] FAIL indep_out0: got valid %b data %h expected valid 1 data 77", out0_valid, out0_data); end
        checks++; if ({out2_valid, out2_data} !== {1'b1, 8'hC2}) begin errors++; $display("[TB] FAIL indep_out2: got valid %b data %h expected valid 1 data c2", out2_valid, out2_data); end
        tick();
        out2_ready = 1'b1;
        tick();
        checks++; if ({cnt2, cnt0} !== {8'd3, 8'd2}) begin errors++; $display("[TB] FAIL indep_cnt: got %h expected 0302", {cnt2, cnt0}); end
    endtask

    task automatic test_simultaneous();
        out0_ready = 1'b0;
        in_sel = 2'b00; in_data = 8'hA0; in_valid = 1'b1;
        tick();
        checks++; if ({out0_valid, out0_data} !== {1'b1, 8'hA0}) begin errors++; $display("[TB] FAIL sim_first: got valid %b data %h expected valid 1 data a0", out0_valid, out0_data); end
        out0_ready = 1'b1; in_data = 8'hB0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL sim_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0; out0_ready = 1'b0;
        checks++; if ({out0_valid, out0_data, cnt0} !== {1'b1, 8'hB0, 8'd3}) begin errors++; $display("[TB] FAIL sim_replace: got valid %b data %h cnt %0d expected valid 1 data b0 cnt 3", out0_valid, out0_data, cnt0); end
        out0_ready = 1'b1;
        tick();
        checks++; if ({out0_valid, cnt0} !== {1'b0, 8'd4}) begin errors++; $display("[TB] FAIL sim_drain: got valid %b cnt %0d expected valid 0 cnt 4", out0_valid, cnt0); end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out0_ready = 1'b1; in_sel = 2'b00; in_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (cnt0 !== 8'd255) begin errors++; $display("[TB] FAIL wrap_255: got %0d expected 255", cnt0); end
        checks++; if (out0_data !== 8'd254) begin errors++; $display("[TB] FAIL wrap_last_data: got %h expected fe", out0_data); end
        in_data = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if ({out0_valid, cnt0} !== {1'b0, 8'd0}) begin errors++; $display("[TB] FAIL wrap_zero: got valid %b cnt %0d expected valid 0 cnt 0", out0_valid, cnt0); end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_independence();
        test_simultaneous();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux3_buf.md
DEMUX3_BUF -- requirements
Module: demux3_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the payload width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-005 The block SHALL have port in_sel, input, 2 bits: the destination select, s[1] s[0].
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream offers in_data/in_sel.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the offer this cycle.
REQ-008 The block SHALL have ports outK_data (output, WIDTH bits), outK_valid (output, 1 bit) and outK_ready (input, 1 bit) for each K = 0, 1, 2: the per-channel downstream stream.
REQ-009 The block SHALL have ports cntK, output, 8 bits, for each K = 0, 1, 2: the count of words delivered on channel K.

Function
REQ-010 The select SHALL decode as: 00 goes to channel 0; 01 goes to channel 1; 10 goes to channel 2; 11 also goes to channel 2.
REQ-011 Each channel SHALL hold one entry, with a two-state machine of EMPTY and FULL; outK_valid SHALL be 1 exactly when the channel is FULL.
REQ-012 A transfer in SHALL occur when in_valid and in_ready are both 1; the word SHALL be captured into the decoded channel at that edge.
REQ-013 A transfer out SHALL occur when outK_valid and outK_ready are both 1.
REQ-014 in_ready SHALL be 1 when the decoded channel is EMPTY, or when it is FULL and its outK_ready is 1 in the same cycle.
  - in_ready is combinational in in_sel and outK_ready.
  - in_ready SHALL NOT depend on in_valid.
REQ-015 Latency SHALL be exactly 1 cycle: a word accepted at edge N SHALL be presented with outK_valid = 1 from edge N onward.
REQ-016 Channel transitions SHALL be:
  - EMPTY to FULL on a transfer in.
  - FULL to EMPTY on a transfer out with no transfer in.
  - FULL stays FULL, with data replaced, on a simultaneous transfer in and transfer out.
REQ-017 While a channel is FULL and not being drained, outK_data SHALL remain stable.
REQ-018 A full or stalled channel SHALL NOT block traffic selected to a different, free channel: there is no head-of-line blocking beyond the single input word.
REQ-019 Channels not addressed by in_sel SHALL be unaffected by the input transfer.
REQ-020 cntK SHALL increment by 1 on each transfer out of channel K and SHALL wrap from 255 to 0.
REQ-021 While a channel is EMPTY, outK_data SHALL hold its last value; no X SHALL be driven after reset.

Reset
REQ-022 When rst_n is 0 at a rising edge, all channels SHALL go to EMPTY.
REQ-023 After that reset edge, every outK_valid SHALL be 0, every outK_data SHALL be 0, and every cntK SHALL be 0.
REQ-024 A reset mid-operation SHALL discard held words without a transfer out and without a count increment.
REQ-025 While rst_n is 0, in_ready SHALL be 0.

Structure
REQ-026 A shared package demux3_pkg SHALL hold:
  - NUM_CH = 3;
  - an enum ch_t of CH0, CH1, CH2;
  - a function sel_to_ch that maps the 2-bit select to ch_t, with 11 mapping to CH2;
  - an enum slot_state_t of EMPTY, FULL.
REQ-027 The block SHALL contain one sub-module, demux_slot: a one-entry buffer with load, drain, state, data and 8-bit counter, instantiated NUM_CH times.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
  - Reset: rst_n = 0 for 2 cycles mid-traffic with channel 1 FULL -> all outK_valid = 0, cntK = 0, in_ready = 0 during reset.
  - Routing: in_sel = 00, 01, 10, 11 with data 0x11, 0x22, 0x33, 0x44 and all outK_ready = 1 -> 0x11 on out0; 0x22 on out1; 0x33 then 0x44 on out2; cnt0 = 1, cnt1 = 1, cnt2 = 2.
  - Backpressure: out1_ready = 0, send 0x5A to channel 1, then 0x6B to channel 1 -> in_ready = 0 on the second word, out1_data holds 0x5A; after out1_ready = 1, 0x5A then 0x6B are delivered in order.
  - Independence: channel 2 stalled and FULL, send 0x77 with in_sel = 00 -> accepted at the same edge, out0_valid = 1 next cycle.
  - Simultaneous: channel 0 FULL with 0xA0, out0_ready = 1 and in_valid = 1 with 0xB0 to channel 0 in the same cycle -> in_ready = 1, out0 shows 0xB0 next cycle, channel stays FULL, cnt0 increments by 1.
  - Wrap: 256 transfers on channel 0 -> cnt0 returns to 0.
